// File: rtl/num_char_render.sv
// Numeric overlay: sequential double-dabble converter feeding a frame-latched
// digit register, composited over the video stream through a 3-stage ROM pipeline.
module num_char_render #(
    parameter int          X_START    = 100,
    parameter int          Y_START    = 50,
    parameter int          NUM_DIGITS = 6,
    parameter int          BIN_WIDTH  = 20,
    parameter logic [23:0] FG_COLOR   = 24'hFFFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIN_WIDTH-1:0] val_in,
    input  logic                 val_valid,
    output logic                 val_ready,
    input  logic [11:0]          pix_x,
    input  logic [11:0]          pix_y,
    input  logic                 de_in,
    input  logic                 hs_in,
    input  logic                 vs_in,
    input  logic [23:0]          rgb_in,
    output logic [9:0]           rom_addr,
    input  logic [23:0]          rom_data,
    output logic                 de_out,
    output logic                 hs_out,
    output logic                 vs_out,
    output logic [23:0]          rgb_out
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_SHIFT = 2'd1;
    localparam logic [1:0]  S_DONE  = 2'd2;
    localparam logic [11:0] X_LO = 12'(X_START);
    localparam logic [11:0] X_HI = 12'(X_START + 24 * NUM_DIGITS - 1);
    localparam logic [11:0] Y_LO = 12'(Y_START);
    localparam logic [11:0] Y_HI = 12'(Y_START + 31);
    localparam logic [4:0]  CNT_LAST = 5'(BIN_WIDTH - 1);
    localparam logic [63:0] LOW_MASK64 = (64'd1 << (4 * NUM_DIGITS)) - 64'd1;
    localparam logic [31:0] HI_MASK = ~LOW_MASK64[31:0];

    logic [1:0]           state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [31:0]          bcd_q, bcd_d, adj;
    logic [31:0]          pend_dig_q, pend_dig_d;
    logic [31:0]          disp_q, disp_d;
    logic                 pend_q, pend_d;
    logic                 vs_prev_q, vs_rise;

    assign val_ready = (state_q == S_IDLE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        pend_dig_d = pend_dig_q;
        pend_d     = pend_q;
        disp_d     = disp_q;
        adj        = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        case (state_q)
            S_IDLE: begin
                if (val_valid) begin
                    bin_d   = val_in;
                    bcd_d   = '0;
                    cnt_d   = CNT_LAST;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d = {adj[30:0], bin_q[BIN_WIDTH-1]};
                bin_d = bin_q << 1;
                if (cnt_q == 5'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 5'd1;
            end
            S_DONE: begin
                // Any nonzero digit beyond the displayed width saturates to all nines.
                pend_dig_d = (|(bcd_q & HI_MASK)) ? {8{4'd9}} : bcd_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        vs_rise = vs_in & ~vs_prev_q;
        if (vs_rise && pend_q) begin
            disp_d = pend_dig_q;
            pend_d = 1'b0;
        end
        if (state_q == S_DONE) pend_d = 1'b1;
    end

    // Stage 1: box decode and glyph address from the incoming pixel.
    logic [11:0]           dx;
    logic [2:0]            dig_idx;
    logic                  in_box, seen_nz, sel_blank;
    logic [3:0]            sel_code;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic [9:0]            rom_addr_q, rom_addr_d;
    logic [4:0]            col1_q, col1_d, col2_q;
    logic                  box1_q, box1_d, box2_q, blank1_q, blank1_d, blank2_q;
    logic [2:0]            sync1_q, sync2_q, sync_out_q;
    logic [23:0]           rgb1_q, rgb2_q, rgb_out_q, rgb_out_d;
    logic                  glyph_bit;

    always_comb begin
        dx      = pix_x - X_LO;
        dig_idx = 3'(dx / 12'd24);
        col1_d  = 5'(dx % 12'd24);
        in_box  = (pix_x >= X_LO) && (pix_x <= X_HI) && (pix_y >= Y_LO) && (pix_y <= Y_HI);
        seen_nz   = 1'b0;
        blank_vec = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (disp_q[4*(NUM_DIGITS-1-d) +: 4] != 4'd0) seen_nz = 1'b1;
            blank_vec[d] = ~seen_nz && (d != NUM_DIGITS - 1);
        end
        sel_code  = 4'd0;
        sel_blank = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (dig_idx == 3'(d)) begin
                sel_code  = disp_q[4*(NUM_DIGITS-1-d) +: 4];
                sel_blank = blank_vec[d];
            end
        end
        rom_addr_d = in_box ? {1'b0, sel_code, 5'(pix_y - Y_LO)} : 10'd0;
        box1_d     = in_box;
        blank1_d   = sel_blank;
    end

    // Stage 3: rom_data is now valid for the pixel held in stage 2.
    always_comb begin
        glyph_bit = rom_data[5'd23 - col2_q];
        rgb_out_d = (sync2_q[2] && box2_q && !blank2_q && glyph_bit) ? FG_COLOR : rgb2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            pend_dig_q <= '0;
            disp_q     <= '0;
            pend_q     <= 1'b0;
            vs_prev_q  <= 1'b0;
            rom_addr_q <= '0;
            col1_q     <= '0;
            col2_q     <= '0;
            box1_q     <= 1'b0;
            box2_q     <= 1'b0;
            blank1_q   <= 1'b0;
            blank2_q   <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync_out_q <= '0;
            rgb1_q     <= '0;
            rgb2_q     <= '0;
            rgb_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            pend_dig_q <= pend_dig_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            vs_prev_q  <= vs_in;
            rom_addr_q <= rom_addr_d;
            col1_q     <= col1_d;
            col2_q     <= col1_q;
            box1_q     <= box1_d;
            box2_q     <= box1_q;
            blank1_q   <= blank1_d;
            blank2_q   <= blank1_q;
            sync1_q    <= {de_in, hs_in, vs_in};
            sync2_q    <= sync1_q;
            sync_out_q <= sync2_q;
            rgb1_q     <= rgb_in;
            rgb2_q     <= rgb1_q;
            rgb_out_q  <= rgb_out_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign de_out   = sync_out_q[2];
    assign hs_out   = sync_out_q[1];
    assign vs_out   = sync_out_q[0];
    assign rgb_out  = rgb_out_q;

endmodule

// File: doc/num_char_render.md
# num_char_render

Numeric overlay renderer for the oscilloscope video path; the reading client of the 24-bit-wide digit glyph ROM (`num_rom`). Accepts a binary measurement value over a valid/ready handshake and converts it to BCD with a sequential double-dabble. At each frame boundary it latches the converted digits. It fetches glyph rows from the ROM in step with the incoming pixel stream and overlays the digits on the video in a fixed box, with all video signals delay-matched.

## Interface
- `X_START`, 100: left pixel column of text box.
- `Y_START`, 50: top pixel row of text box.
- `NUM_DIGITS`, 6: displayed digits, legal 1..8.
- `BIN_WIDTH`, 20: width of `val_in`, legal 4..26.
- `FG_COLOR`, 24'hFFFFFF: glyph pixel colour.
- `clk` in 1: pixel clock; sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `val_in` in BIN_WIDTH: unsigned value to display.
- `val_valid` in 1: `val_in` valid.
- `val_ready` out 1: converter idle, can accept.
- `pix_x`, `pix_y` in 12 each: coordinates of the current input pixel.
- `de_in`, `hs_in`, `vs_in` in 1 each: video timing; `vs_in` active-high.
- `rgb_in` in 24: background pixel.
- `rom_addr` out 10: glyph ROM address, {code[4:0], row[4:0]}.
- `rom_data` in 24: ROM read data; synchronous read, valid 1 cycle after `rom_addr`.
- `de_out`, `hs_out`, `vs_out` out 1 each: timing outputs, delayed 3 cycles.
- `rgb_out` out 24: composited pixel, delayed 3 cycles.

## Operation
- Glyph format: 24 wide x 32 tall. Codes 0..9 are digits. Bit `rom_data[23-c]` is column c, MSB leftmost. Codes 10..31 are not used.
- Converter FSM:
  - IDLE: `val_ready`=1. `val_valid`&`val_ready` captures `val_in` and moves to SHIFT.
  - SHIFT: BIN_WIDTH cycles, one double-dabble iteration per cycle, into 8 BCD digits.
  - DONE: one cycle. Writes the result to the pending register, sets `pend`, returns to IDLE.
- `val_valid` while `val_ready`=0 is ignored.
- Overflow: if the value is ≥ 10^NUM_DIGITS, the pending digits become all 9.
- A new result overwrites an un-applied pending result.
- Frame update: on a registered rising edge of `vs_in` with `pend`=1, the pending digits are copied to the display register and `pend` is cleared.
- Box: x in [X_START, X_START+24·NUM_DIGITS-1], y in [Y_START, Y_START+31].
  - dx = pix_x-X_START; digit d = dx/24 (d=0 leftmost); col = dx%24; row = pix_y-Y_START.
- Address generation: inside the box, `rom_addr` = {display digit d, row}. Outside the box, `rom_addr`=0.
- Leading-zero blanking: digits left of the first nonzero digit are blank. The rightmost digit is never blanked.
- Compositing: `rgb_out` = FG_COLOR when the delayed de_in=1, the pixel is inside the box, the digit is not blank, and the glyph bit is 1. Otherwise `rgb_out` is the delayed `rgb_in`.
- Reset:
  - all outputs 0 except `val_ready`=1;
  - FSM=IDLE; display and pending digits all 0; `pend`=0.
  - Reset mid-conversion aborts it; no pending write.

## Timing
- Pixel at input cycle N:
  - `rom_addr` registered, valid in N+1;
  - `rom_data` valid in N+2;
  - all outputs registered, valid in N+3.
- Latency is fixed at 3 and applies equally to de/hs/vs/rgb; no bubbles.
- Converter: acceptance at edge C. `val_ready` is low from C+1 and high again at C+BIN_WIDTH+2. Pending is written at the last low cycle.
- Display changes only on the cycle after a detected `vs_in` rise; it is never updated mid-frame.
- Acceptance and a vs rise in the same cycle are independent. The vs rise applies the old pending value.

## Test plan
- Reset then one frame, ROM model returning 24'hFFFFFF:
  - `val_ready`=1; all outputs 0 during reset.
  - In box, only digit 5 (x 220..243) shows FG_COLOR; digits 0..4 pass `rgb_in`.
- `val_in`=123456 accepted:
  - `val_ready` low exactly 21 cycles.
  - After the next vs rise, at x=100, y=53: `rom_addr`=10'h023 ({5'd1, 5'd3}).
- Alignment, ROM model returning 24'h800001, value 0:
  - pixel x=220 → FG_COLOR at `rgb_out` 3 cycles later;
  - x=221 → `rgb_in`; x=243 → FG_COLOR;
  - `hs_out`/`vs_out`/`de_out` equal the inputs delayed 3.
- `val_in`=42: digits 0..3 blank, digit 4 address code 4, digit 5 code 2. `val_in`=1000000 → displays 999999.
- Two values accepted between vs rises, 11 then 22 → frame shows 22. `val_valid` pulsed while busy → value dropped.
- `rst` asserted 5 cycles into a conversion of 777:
  - immediate `val_ready`=1, outputs 0;
  - display 0 after the next frame;
  - no 777 ever shown.
